cache_refill_arbiter: RTL

- Shares the single main-memory read/write port between the instruction-side and data-side caches.
- Sequences block refills on a cache miss: issues 2**BLOCK_SIZE word reads, collects the returned words into one block and hands the block to the requesting cache.
- Also performs single-word write-through transfers for the data side.
- Sits between the two cache instances and the memory model/bus.

---
 rtl/cache_refill_arbiter.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/cache_refill_arbiter.sv
// Shares one memory port between I- and D-cache: block refills
// for either side, single-word write-through for the D side.
module cache_refill_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 30,
  parameter int BLOCK_SIZE    = 3,
  localparam int JUST_DATA    = DATA_WIDTH * (2**BLOCK_SIZE)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_req,
  input  logic [ADDRESS_WIDTH-1:0] i_addr,
  output logic                     i_done,
  input  logic                     d_req,
  input  logic                     d_we,
  input  logic [ADDRESS_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0]    d_wdata,
  output logic                     d_done,
  output logic [JUST_DATA-1:0]     fill_block,
  output logic [1:0]               grant,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic                     mem_rd,
  output logic                     mem_wr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic                     mem_ready,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  input  logic                     mem_rvalid
);

  localparam int NWORDS = 2**BLOCK_SIZE;
  localparam int CW     = BLOCK_SIZE + 1;
  localparam int AW     = ADDRESS_WIDTH;
  localparam int DW     = DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      grant_q;
  logic            last_d_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [CW-1:0]   issue_q;
  logic [CW-1:0]   rx_q;
  logic [JUST_DATA-1:0] fill_q;

  logic            any_req;
  logic            pick_d;
  logic            last_beat;
  logic [AW-1:0]   sel_addr;
  logic [AW-1:0]   cap_addr;

  assign any_req   = i_req | d_req;
  // Round-robin tie break: the side that did not own the port last.
  assign pick_d    = d_req & (~i_req | ~last_d_q);
  assign last_beat = mem_rvalid & (rx_q == CW'(NWORDS - 1));
  assign sel_addr  = pick_d ? d_addr : i_addr;
  assign cap_addr  = (pick_d & d_we) ? d_addr :
                     {sel_addr[AW-1:BLOCK_SIZE], {BLOCK_SIZE{1'b0}}};

  assign grant      = grant_q;
  assign fill_block = fill_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = (pick_d & d_we) ? WRITE : READ;
        end
      end
      READ: begin
        if (last_beat) begin
          state_d = DONE;
        end
      end
      WRITE: begin
        if (mem_ready) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    i_done    = 1'b0;
    d_done    = 1'b0;
    unique case (state_q)
      READ: begin
        if (issue_q < CW'(NWORDS)) begin
          mem_rd   = 1'b1;
          mem_addr = {addr_q[AW-1:BLOCK_SIZE],
                      issue_q[BLOCK_SIZE-1:0]};
        end
      end
      WRITE: begin
        mem_wr    = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
      end
      DONE: begin
        i_done = ~last_d_q;
        d_done = last_d_q;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_q  <= '0;
      last_d_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      issue_q  <= '0;
      rx_q     <= '0;
      fill_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (any_req) begin
            grant_q  <= {pick_d, ~pick_d};
            last_d_q <= pick_d;
            addr_q   <= cap_addr;
            wdata_q  <= d_wdata;
          end
        end
        READ: begin
          if (mem_rd && mem_ready) begin
            issue_q <= issue_q + CW'(1);
          end
          if (mem_rvalid) begin
            fill_q[rx_q[BLOCK_SIZE-1:0]*DW +: DW] <= mem_rdata;
            rx_q <= rx_q + CW'(1);
          end
          // Owner stays in last_d_q so DONE can pulse the right side.
          if (last_beat) begin
            grant_q <= '0;
          end
        end
        WRITE: begin
          if (mem_ready) begin
            grant_q <= '0;
          end
        end
        DONE: begin
          grant_q <= '0;
          issue_q <= '0;
          rx_q    <= '0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
